voice_allocator: RTL and testbench

//  Polyphony scheduler for the piano datapath. Takes 8 raw key lines (t0..t7, packed as keys[7:0]).
//  - Debounces each key and assigns held keys to NUM_VOICES oscillator slots (divfreq + rom pairs).
//  - Drives per-voice enable, note index and restart pulse.
//  - Drives mix_shift, which the output mixer uses to normalise the summed voice waveforms.

---
 rtl/voice_if.sv | 30 +++
 rtl/voice_allocator.sv | 197 +++++++++++++++++++
 tb/tb_voice_allocator.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/voice_if.sv
// voice_if: key lines in, per-voice oscillator controls and mixer normalisation out.
// master = allocator side, slave = datapath / bench side.
interface voice_if #(
  parameter int NUM_VOICES = 4
);
  logic [7:0]              keys;
  logic [NUM_VOICES-1:0]   voice_en;
  logic [3*NUM_VOICES-1:0] voice_note;
  logic [NUM_VOICES-1:0]   voice_start;
  logic [3:0]              active_cnt;
  logic [2:0]              mix_shift;

  modport master (
    input  keys,
    output voice_en,
    output voice_note,
    output voice_start,
    output active_cnt,
    output mix_shift
  );

  modport slave (
    output keys,
    input  voice_en,
    input  voice_note,
    input  voice_start,
    input  active_cnt,
    input  mix_shift
  );
endinterface

// File: rtl/voice_allocator.sv
// voice_allocator: debounced 8-key scanner sharing NUM_VOICES oscillator slots.
// Define VOICE_STEAL_EN to let a new key steal the oldest slot when all are busy.
module voice_allocator #(
  parameter int NUM_VOICES    = 4,
  parameter int DEBOUNCE_BITS = 16,
  parameter int AGE_BITS      = 8
) (
  input  logic    clk,
  input  logic    rst,
  voice_if.master vif
);

  localparam int NV = NUM_VOICES;
  localparam int VW = (NV > 1) ? $clog2(NV) : 1;
  localparam int DB = DEBOUNCE_BITS;

  localparam logic [DB-1:0] CNT_LAST =
    {{(DB-1){1'b1}}, 1'b0};
  localparam logic [AGE_BITS-1:0] AGE_MAX = '1;

  typedef enum logic [1:0] {
    ACT_NONE,
    ACT_FREE,
    ACT_ALLOC,
    ACT_STEAL
  } act_e;

  logic [7:0]          sync1;
  logic [7:0]          sync2;
  logic [7:0]          stable;
  logic [DB-1:0]       cnt [8];
  logic [7:0]          assigned;
  logic [7:0]          dropped;
  logic [2:0]          scan_ptr;
  logic [NV-1:0]       en_q;
  logic [NV-1:0]       start_q;
  logic [2:0]          note_q [NV];
  logic [AGE_BITS-1:0] age_q [NV];
  logic [3:0]          act_q;
  logic [2:0]          shift_q;

  logic [2:0]          k;
  logic                want;
  logic                have_free;
  logic [VW-1:0]       free_v;
  logic [VW-1:0]       hold_v;
  logic [VW-1:0]       tgt_v;
  act_e                act;
  logic [3:0]          pop;
  logic [2:0]          shift_d;
  logic [3*NV-1:0]     note_flat;

  // Reaching the last count value is the (2^DB-1)th differing cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1  <= '0;
      sync2  <= '0;
      stable <= '0;
      for (int i = 0; i < 8; i++) cnt[i] <= '0;
    end else begin
      sync1 <= vif.keys;
      sync2 <= sync1;
      for (int i = 0; i < 8; i++) begin
        if (sync2[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          stable[i] <= ~stable[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  assign k    = scan_ptr;
  assign want = stable[k] & ~assigned[k] & ~dropped[k];

  always_comb begin
    have_free = 1'b0;
    free_v    = '0;
    hold_v    = '0;
    for (int v = NV - 1; v >= 0; v--) begin
      if (!en_q[v]) begin
        have_free = 1'b1;
        free_v    = VW'(v);
      end
      if (en_q[v] && note_q[v] == k) hold_v = VW'(v);
    end
  end

`ifdef VOICE_STEAL_EN
  logic [VW-1:0]       old_v;
  logic [AGE_BITS-1:0] old_age;

  always_comb begin
    old_v   = '0;
    old_age = age_q[0];
    for (int v = 1; v < NV; v++) begin
      if (age_q[v] > old_age) begin
        old_age = age_q[v];
        old_v   = VW'(v);
      end
    end
  end

  assign tgt_v = (act == ACT_STEAL) ? old_v : free_v;
`else
  assign tgt_v = free_v;
`endif

  always_comb begin
    act = ACT_NONE;
    unique case (1'b1)
      (!stable[k] && assigned[k]): act = ACT_FREE;
      (want && have_free):         act = ACT_ALLOC;
`ifdef VOICE_STEAL_EN
      (want && !have_free):        act = ACT_STEAL;
`endif
      default:                     act = ACT_NONE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      scan_ptr <= '0;
      assigned <= '0;
      dropped  <= '0;
      en_q     <= '0;
      start_q  <= '0;
      for (int v = 0; v < NV; v++) begin
        note_q[v] <= '0;
        age_q[v]  <= '0;
      end
    end else begin
      scan_ptr <= scan_ptr + 3'd1;
      start_q  <= '0;
      if (!stable[k]) dropped[k] <= 1'b0;
      case (act)
        ACT_FREE: begin
          en_q[hold_v] <= 1'b0;
          assigned[k]  <= 1'b0;
        end
        ACT_ALLOC, ACT_STEAL: begin
          for (int v = 0; v < NV; v++) begin
            if (VW'(v) != tgt_v && en_q[v] && age_q[v] != AGE_MAX)
              age_q[v] <= age_q[v] + 1'b1;
          end
`ifdef VOICE_STEAL_EN
          if (act == ACT_STEAL) begin
            assigned[note_q[tgt_v]] <= 1'b0;
            dropped[note_q[tgt_v]]  <= 1'b1;
          end
`endif
          en_q[tgt_v]    <= 1'b1;
          note_q[tgt_v]  <= k;
          age_q[tgt_v]   <= '0;
          start_q[tgt_v] <= 1'b1;
          assigned[k]    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    pop = '0;
    for (int v = 0; v < NV; v++) pop = pop + 4'(en_q[v]);
    if (pop <= 4'd1)      shift_d = 3'd0;
    else if (pop == 4'd2) shift_d = 3'd1;
    else if (pop <= 4'd4) shift_d = 3'd2;
    else                  shift_d = 3'd3;
  end

  // Mixer normalisation lags voice_en by one register stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      act_q   <= '0;
      shift_q <= '0;
    end else begin
      act_q   <= pop;
      shift_q <= shift_d;
    end
  end

  always_comb begin
    note_flat = '0;
    for (int v = 0; v < NV; v++) note_flat[3*v +: 3] = note_q[v];
  end

  assign vif.voice_en    = en_q;
  assign vif.voice_note  = note_flat;
  assign vif.voice_start = start_q;
  assign vif.active_cnt  = act_q;
  assign vif.mix_shift   = shift_q;

endmodule

// File: tb/tb_voice_allocator.sv
// tb_voice_allocator: directed scenarios plus random key traffic,
// every cycle compared against a rule-level reference model.
module tb_voice_allocator;

  localparam int NV   = 4;
  localparam int DB   = 4;
  localparam int AB   = 8;
  localparam int RUN  = (1 << DB) - 1;
  localparam int AMAX = (1 << AB) - 1;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  voice_if #(.NUM_VOICES(NV)) vif();

  voice_allocator #(
    .NUM_VOICES   (NV),
    .DEBOUNCE_BITS(DB),
    .AGE_BITS     (AB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .vif(vif)
  );

  int n_chk = 0;
  int n_err = 0;

  int m_s1[8], m_s2[8], m_stab[8], m_run[8];
  int m_asg[8], m_drop[8];
  int m_ptr;
  int m_en[NV], m_note[NV], m_age[NV], m_start[NV];
  int m_act, m_shift;
  int npulse[NV];

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] bits_of(input int a[NV]);
    logic [31:0] r = '0;
    for (int v = 0; v < NV; v++) r[v] = (a[v] != 0);
    return r;
  endfunction

  function automatic logic [31:0] notes_of(input int a[NV]);
    logic [31:0] r = '0;
    for (int v = 0; v < NV; v++) r[3*v +: 3] = 3'(a[v]);
    return r;
  endfunction

  // One rising edge of the spec's rules, all decisions from pre-edge state.
  task automatic model_edge(input bit r, input bit [7:0] kin);
    int cnt, key, tgt;
    if (r) begin
      for (int i = 0; i < 8; i++) begin
        m_s1[i] = 0; m_s2[i] = 0; m_stab[i] = 0;
        m_run[i] = 0; m_asg[i] = 0; m_drop[i] = 0;
      end
      for (int v = 0; v < NV; v++) begin
        m_en[v] = 0; m_note[v] = 0; m_age[v] = 0; m_start[v] = 0;
      end
      m_ptr = 0; m_act = 0; m_shift = 0;
      return;
    end
    cnt = 0;
    for (int v = 0; v < NV; v++) cnt += m_en[v];
    m_act   = cnt;
    m_shift = (cnt <= 1) ? 0 : (cnt == 2) ? 1 : (cnt <= 4) ? 2 : 3;
    for (int v = 0; v < NV; v++) m_start[v] = 0;
    key = m_ptr;
    if (m_stab[key] == 0) begin
      m_drop[key] = 0;
      if (m_asg[key] != 0) begin
        for (int v = 0; v < NV; v++)
          if (m_en[v] != 0 && m_note[v] == key) m_en[v] = 0;
        m_asg[key] = 0;
      end
    end else if (m_asg[key] == 0 && m_drop[key] == 0) begin
      tgt = -1;
      for (int v = NV - 1; v >= 0; v--) if (m_en[v] == 0) tgt = v;
`ifdef VOICE_STEAL_EN
      if (tgt < 0) begin
        tgt = 0;
        for (int v = 1; v < NV; v++) if (m_age[v] > m_age[tgt]) tgt = v;
        m_asg[m_note[tgt]]  = 0;
        m_drop[m_note[tgt]] = 1;
      end
`endif
      if (tgt >= 0) begin
        for (int v = 0; v < NV; v++)
          if (v != tgt && m_en[v] != 0 && m_age[v] < AMAX) m_age[v]++;
        m_en[tgt] = 1; m_note[tgt] = key; m_age[tgt] = 0;
        m_start[tgt] = 1; m_asg[key] = 1;
      end
    end
    m_ptr = (m_ptr + 1) % 8;
    for (int i = 0; i < 8; i++) begin
      if (m_s2[i] != m_stab[i]) begin
        m_run[i]++;
        if (m_run[i] == RUN) begin
          m_stab[i] = 1 - m_stab[i];
          m_run[i]  = 0;
        end
      end else begin
        m_run[i] = 0;
      end
      m_s2[i] = m_s1[i];
      m_s1[i] = int'(kin[i]);
    end
  endtask

  task automatic tick(input bit r, input bit [7:0] kin);
    rst      = r;
    vif.keys = kin;
    @(posedge clk);
    model_edge(r, kin);
    #1;
    chk("voice_en",    32'(vif.voice_en),    bits_of(m_en));
    chk("voice_note",  32'(vif.voice_note),  notes_of(m_note));
    chk("voice_start", 32'(vif.voice_start), bits_of(m_start));
    chk("active_cnt",  32'(vif.active_cnt),  32'(m_act));
    chk("mix_shift",   32'(vif.mix_shift),   32'(m_shift));
    for (int v = 0; v < NV; v++) if (vif.voice_start[v]) npulse[v]++;
  endtask

  task automatic clr_pulses();
    for (int v = 0; v < NV; v++) npulse[v] = 0;
  endtask

  function automatic int pulses();
    int s = 0;
    for (int v = 0; v < NV; v++) s += npulse[v];
    return s;
  endfunction

  function automatic int slot_note(input int v);
    logic [3*NV-1:0] nv;
    nv = vif.voice_note;
    return int'(nv[3*v +: 3]);
  endfunction

  initial begin
    bit [7:0] kv;
    int       shift_tab[4];
    shift_tab = '{0, 1, 2, 2};
    rst      = 1'b1;
    vif.keys = '0;

    tick(1'b1, 8'h00);
    chk("rst_en",    32'(vif.voice_en),   32'h0);
    chk("rst_cnt",   32'(vif.active_cnt), 32'h0);
    chk("rst_start", 32'(vif.voice_start), 32'h0);

    clr_pulses();
    repeat (40) tick(1'b0, 8'h00);
    chk("idle_en",     32'(vif.voice_en),   32'h0);
    chk("idle_cnt",    32'(vif.active_cnt), 32'h0);
    chk("idle_shift",  32'(vif.mix_shift),  32'h0);
    chk("idle_pulses", 32'(pulses()),       32'h0);

    clr_pulses();
    repeat (40) tick(1'b0, 8'h04);
    chk("k2_en",     32'(vif.voice_en),   32'h1);
    chk("k2_note",   32'(slot_note(0)),   32'd2);
    chk("k2_pulse",  32'(npulse[0]),      32'd1);
    chk("k2_cnt",    32'(vif.active_cnt), 32'd1);
    chk("k2_shift",  32'(vif.mix_shift),  32'd0);
    repeat (40) tick(1'b0, 8'h00);
    chk("k2_rel_en", 32'(vif.voice_en),   32'h0);

    clr_pulses();
    repeat (5)  tick(1'b0, 8'h04);
    repeat (40) tick(1'b0, 8'h00);
    chk("glitch_pulses", 32'(pulses()),     32'h0);
    chk("glitch_en",     32'(vif.voice_en), 32'h0);

    kv = '0;
    for (int i = 0; i < 4; i++) begin
      kv[i] = 1'b1;
      repeat (40) tick(1'b0, kv);
      chk("seq_cnt",   32'(vif.active_cnt), 32'(i + 1));
      chk("seq_shift", 32'(vif.mix_shift),  32'(shift_tab[i]));
      chk("seq_note",  32'(slot_note(i)),   32'(i));
    end

    clr_pulses();
    repeat (40) tick(1'b0, 8'h2f);
`ifdef VOICE_STEAL_EN
    chk("steal_note",  32'(slot_note(0)),  32'd5);
    chk("steal_pulse", 32'(npulse[0]),     32'd1);
    chk("steal_en",    32'(vif.voice_en),  32'hf);
    repeat (40) tick(1'b0, 8'h2d);
    chk("steal_rel_en", 32'(vif.voice_en), 32'hd);
`else
    chk("full_note",   32'(slot_note(0)),  32'd0);
    chk("full_pulses", 32'(pulses()),      32'd0);
    repeat (40) tick(1'b0, 8'h2d);
    chk("retry_note",  32'(slot_note(1)),  32'd5);
    chk("retry_en",    32'(vif.voice_en),  32'hf);
`endif
    repeat (40) tick(1'b0, 8'h00);
    chk("all_rel_en", 32'(vif.voice_en), 32'h0);

    repeat (43) tick(1'b0, 8'h81);
    chk("pre_rst_en", 32'(vif.voice_en), 32'h3);
    tick(1'b1, 8'h81);
    chk("mid_rst_en",    32'(vif.voice_en),    32'h0);
    chk("mid_rst_cnt",   32'(vif.active_cnt),  32'h0);
    chk("mid_rst_shift", 32'(vif.mix_shift),   32'h0);
    chk("mid_rst_start", 32'(vif.voice_start), 32'h0);
    repeat (40) tick(1'b0, 8'h81);
    chk("post_rst_en",    32'(vif.voice_en),   32'h3);
    chk("post_rst_shift", 32'(vif.mix_shift),  32'h1);

    kv = '0;
    repeat (3000) begin
      bit r;
      r = ($urandom_range(0, 999) == 0);
      if ($urandom_range(0, 15) == 0)
        kv[$urandom_range(0, 7)] ^= 1'b1;
      if ($urandom_range(0, 31) == 0)
        tick(r, kv ^ (8'h01 << $urandom_range(0, 7)));
      else
        tick(r, kv);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
